// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter and write sequencer for a single shared WIDTH-bit
// register. Requesters compete for write access. Each grant ends in either
// one capture of the winner's data followed by a one-cycle ack, or an abort
// with no write and no ack. The shared register can be cleared synchronously.
module dff_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*WIDTH-1:0]     wdata,
  input  logic                      clr,
  output logic [NREQ-1:0]           gnt,
  output logic [NREQ-1:0]           ack,
  output logic [$clog2(NREQ)-1:0]   owner,
  output logic [WIDTH-1:0]          q,
  output logic                      q_valid,
  output logic                      busy
);

  localparam int PW = $clog2(NREQ);
  localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);
  localparam logic [PW-1:0]   LAST_IDX = PW'(NREQ - 1);
  localparam logic [PW:0]     NREQ_EXT = (PW+1)'(NREQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [PW-1:0]     ptr_r, ptr_s;
  logic [PW-1:0]     win_r, win_s;
  logic [NREQ-1:0]   gnt_r, gnt_s;
  logic [NREQ-1:0]   ack_r, ack_s;
  logic [PW-1:0]     owner_r, owner_s;
  logic [WIDTH-1:0]  q_r, q_s;
  logic              q_valid_r, q_valid_s;
  logic              busy_r;

  logic              rr_found_s;
  logic [PW-1:0]     rr_win_s;
  logic [PW:0]       rr_sum_s;
  logic [PW-1:0]     rr_cand_s;

  // Round-robin search: first set request starting at ptr, wrapping to 0.
  always_comb begin
    rr_found_s = 1'b0;
    rr_win_s   = '0;
    rr_sum_s   = '0;
    rr_cand_s  = '0;
    for (int k = 0; k < NREQ; k++) begin
      rr_sum_s = {1'b0, ptr_r} + (PW+1)'(k);
      if (rr_sum_s >= NREQ_EXT) begin
        rr_sum_s = rr_sum_s - NREQ_EXT;
      end else begin
        rr_sum_s = rr_sum_s;
      end
      rr_cand_s = rr_sum_s[PW-1:0];
      if (!rr_found_s && req[rr_cand_s]) begin
        rr_found_s = 1'b1;
        rr_win_s   = rr_cand_s;
      end else begin
        rr_found_s = rr_found_s;
      end
    end
  end

  // Next-state and next-output logic; clr overrides any write in any state.
  always_comb begin
    state_s   = state_r;
    ptr_s     = ptr_r;
    win_s     = win_r;
    gnt_s     = '0;
    ack_s     = '0;
    owner_s   = owner_r;
    q_s       = q_r;
    q_valid_s = q_valid_r;

    if (clr) begin
      q_s       = '0;
      q_valid_s = 1'b0;
    end else begin
      q_s       = q_r;
    end

    case (state_r)
      IDLE: begin
        if (!clr && rr_found_s) begin
          gnt_s   = ONE_HOT0 << rr_win_s;
          win_s   = rr_win_s;
          state_s = GRANT;
        end else begin
          state_s = IDLE;
        end
      end
      GRANT: begin
        state_s = IDLE;
        if (!clr && req[win_r]) begin
          q_s       = wdata[win_r*WIDTH +: WIDTH];
          q_valid_s = 1'b1;
          owner_s   = win_r;
          ack_s     = ONE_HOT0 << win_r;
          ptr_s     = (win_r == LAST_IDX) ? '0 : win_r + PW'(1);
          state_s   = ACK;
        end else begin
          state_s   = IDLE;
        end
      end
      ACK: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers; async reset returns everything to idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      ptr_r     <= '0;
      win_r     <= '0;
      gnt_r     <= '0;
      ack_r     <= '0;
      owner_r   <= '0;
      q_r       <= '0;
      q_valid_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      ptr_r     <= ptr_s;
      win_r     <= win_s;
      gnt_r     <= gnt_s;
      ack_r     <= ack_s;
      owner_r   <= owner_s;
      q_r       <= q_s;
      q_valid_r <= q_valid_s;
      busy_r    <= (state_s != IDLE);
    end
  end

  assign gnt     = gnt_r;
  assign ack     = ack_r;
  assign owner   = owner_r;
  assign q       = q_r;
  assign q_valid = q_valid_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed bench for dff_bank_arbiter: reset, basic write, round-robin order
// with wrap, abort, clr in GRANT and IDLE, async reset mid-transaction, and
// a held request re-granted after its ack.
module tb_dff_bank_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic        clr;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic [1:0]  owner;
  logic [7:0]  q;
  logic        q_valid;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  dff_bank_arbiter #(.NREQ(4), .WIDTH(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .wdata   (wdata),
    .clr     (clr),
    .gnt     (gnt),
    .ack     (ack),
    .owner   (owner),
    .q       (q),
    .q_valid (q_valid),
    .busy    (busy)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, sample 1 time unit later, check invariants.
  task automatic step();
    @(posedge clk);
    #1;
    chk("gnt_ack_excl", 32'((|gnt) && (|ack)), 32'd0);
    chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
    chk("ack_onehot0", 32'($onehot0(ack)), 32'd1);
  endtask

  initial begin
    reset = 1'b0;
    req   = 4'b0000;
    wdata = 32'h0000_0000;
    clr   = 1'b0;

    // Reset values
    @(posedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_qv", 32'(q_valid), 32'h0);
    chk("rst_owner", 32'(owner), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    #2 reset = 1'b1;

    // 1: single write from requester 1
    req   = 4'b0010;
    wdata = 32'h0000_A500;
    step();
    chk("t1_gnt", 32'(gnt), 32'h2);
    chk("t1_ack0", 32'(ack), 32'h0);
    chk("t1_busy", 32'(busy), 32'h1);
    chk("t1_q0", 32'(q), 32'h0);
    step();
    chk("t1_q", 32'(q), 32'hA5);
    chk("t1_qv", 32'(q_valid), 32'h1);
    chk("t1_ack", 32'(ack), 32'h2);
    chk("t1_owner", 32'(owner), 32'h1);
    chk("t1_gnt0", 32'(gnt), 32'h0);
    req = 4'b0000;
    step();
    chk("t1_idle", 32'(busy), 32'h0);
    chk("t1_ack_end", 32'(ack), 32'h0);

    // Re-reset so the pointer starts at 0
    reset = 1'b0;
    #2 reset = 1'b1;

    // 2: all requesters, order 0..3 twice (pointer wraps 3 -> 0)
    wdata = 32'h4433_2211;
    for (int rep = 0; rep < 2; rep++) begin
      req = 4'b1111;
      for (int i = 0; i < 4; i++) begin
        step();
        chk("t2_gnt", 32'(gnt), 32'(1) << i);
        step();
        chk("t2_ack", 32'(ack), 32'(1) << i);
        chk("t2_owner", 32'(owner), 32'(i));
        chk("t2_q", 32'(q), 32'h11 * 32'(i + 1));
        req[i] = 1'b0;
        step();
        chk("t2_idle", 32'(busy), 32'h0);
        chk("t2_gnt_idle", 32'(gnt), 32'h0);
      end
    end

    // 3: abort in GRANT, pointer stays at 0
    req = 4'b0100;
    step();
    chk("t3_gnt", 32'(gnt), 32'h4);
    req = 4'b0000;
    step();
    chk("t3_gnt0", 32'(gnt), 32'h0);
    chk("t3_ack0", 32'(ack), 32'h0);
    chk("t3_busy", 32'(busy), 32'h0);
    chk("t3_q", 32'(q), 32'h44);
    chk("t3_owner", 32'(owner), 32'h3);
    req = 4'b0110;
    step();
    chk("t3_gnt_rr", 32'(gnt), 32'h2);
    step();
    chk("t3_ack", 32'(ack), 32'h2);
    chk("t3_q2", 32'(q), 32'h22);
    req = 4'b0000;
    step();

    // 4: clr during GRANT of requester 0 (pointer at 2)
    wdata[7:0] = 8'h3C;
    req = 4'b0001;
    step();
    chk("t4_gnt", 32'(gnt), 32'h1);
    clr = 1'b1;
    step();
    chk("t4_q", 32'(q), 32'h0);
    chk("t4_qv", 32'(q_valid), 32'h0);
    chk("t4_ack", 32'(ack), 32'h0);
    chk("t4_gnt0", 32'(gnt), 32'h0);
    chk("t4_busy", 32'(busy), 32'h0);
    clr = 1'b0;
    step();
    chk("t4_regnt", 32'(gnt), 32'h1);
    step();
    chk("t4_ack2", 32'(ack), 32'h1);
    chk("t4_q2", 32'(q), 32'h3C);
    chk("t4_qv2", 32'(q_valid), 32'h1);
    chk("t4_owner", 32'(owner), 32'h0);
    req = 4'b0000;
    step();

    // clr in IDLE blocks the grant for that cycle (pointer at 1)
    req = 4'b0010;
    clr = 1'b1;
    step();
    chk("ci_gnt", 32'(gnt), 32'h0);
    chk("ci_busy", 32'(busy), 32'h0);
    chk("ci_qv", 32'(q_valid), 32'h0);
    clr = 1'b0;
    step();
    chk("ci_gnt2", 32'(gnt), 32'h2);
    step();
    chk("ci_q", 32'(q), 32'h22);
    req = 4'b0000;
    step();

    // 5: async reset between grant and write (pointer at 2)
    req = 4'b1000;
    step();
    chk("t5_gnt", 32'(gnt), 32'h8);
    reset = 1'b0;
    #1;
    chk("t5_gnt0", 32'(gnt), 32'h0);
    chk("t5_ack0", 32'(ack), 32'h0);
    chk("t5_q", 32'(q), 32'h0);
    chk("t5_qv", 32'(q_valid), 32'h0);
    chk("t5_busy", 32'(busy), 32'h0);
    chk("t5_owner", 32'(owner), 32'h0);
    #1 reset = 1'b1;
    req = 4'b1010;
    step();
    chk("t5_ptr0", 32'(gnt), 32'h2);
    step();
    chk("t5_ack", 32'(ack), 32'h2);
    req = 4'b0000;
    step();

    // 6: requester 3 holds req through ACK (pointer at 2)
    wdata = 32'h5A00_0099;
    req = 4'b1000;
    step();
    chk("t6_gnt", 32'(gnt), 32'h8);
    wdata[7:0] = 8'h77;
    step();
    chk("t6_ack", 32'(ack), 32'h8);
    chk("t6_q", 32'(q), 32'h5A);
    chk("t6_gnt0", 32'(gnt), 32'h0);
    step();
    chk("t6_ack0", 32'(ack), 32'h0);
    chk("t6_gnt_idle", 32'(gnt), 32'h0);
    chk("t6_idle", 32'(busy), 32'h0);
    step();
    chk("t6_gnt2", 32'(gnt), 32'h8);
    chk("t6_busy2", 32'(busy), 32'h1);
    step();
    chk("t6_ack2", 32'(ack), 32'h8);
    chk("t6_owner", 32'(owner), 32'h3);
    req = 4'b0000;
    step();
    chk("t6_end", 32'(busy), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
